neural_layer_engine: RTL and testbench
======================================

NEURAL_LAYER_ENGINE -- requirements
Module: neural_layer_engine

Interface
REQ-001 Parameter DATA_W, default 8, sets the signed width of activations and weights.
REQ-002 Parameter ACC_W, default 20, sets the signed accumulator width (ACC_W >= 2*DATA_W).
REQ-003 Parameter N, default 4, sets the neurons per layer; every layer has N inputs and N outputs.
REQ-004 Parameter L, default 2, sets the number of layers evaluated per run.
REQ-005 Parameter FRAC_BITS, default 4, sets the arithmetic right shift applied to the accumulator before saturation.
REQ-006 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-007 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 Port start, input, 1 bit: request to begin a run; sampled only in IDLE.
REQ-009 Ports load_valid/load_ready/load_data (in/out/in, 1/1/DATA_W): input-vector stream.
REQ-010 Ports weight_addr (out, clog2(L*N*N)) and weight_data (in, DATA_W): external weight ROM port with a registered read of exactly 1 cycle latency.
REQ-011 Ports out_valid/out_ready/out_data (out/in/out, 1/1/DATA_W): result stream.
REQ-012 Ports busy (out, 1) and done (out, 1): busy is high outside IDLE; done is a 1-cycle pulse.

Function
REQ-013 The FSM SHALL have states IDLE, LOAD, COMPUTE, OUTPUT; IDLE->LOAD on start, LOAD->COMPUTE after N accepted beats, COMPUTE->OUTPUT after layer L-1 neuron N-1 writeback, OUTPUT->IDLE after N accepted beats.
REQ-014 load_ready SHALL be high only in LOAD; beat i (i = 0..N-1) writes activation buffer A[i]; no further beats are accepted.
REQ-015 Activations SHALL be held in two N-entry ping-pong buffers; layer l reads one buffer and writes the other, and the roles swap at each layer boundary.
REQ-016 For layer l, neuron j, input k, weight_addr SHALL equal l*N*N + j*N + k.
REQ-017 Each neuron SHALL take exactly N+2 cycles: N address-issue cycles, 1 pipeline cycle, and 1 writeback cycle; the accumulator clears at the first issue cycle.
REQ-018 The accumulator SHALL add the full-precision signed product act*weight every cycle with no intermediate saturation.
REQ-019 At writeback, result = acc >>> FRAC_BITS, saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-020 The COMPUTE phase SHALL last exactly L*N*(N+2) cycles.
REQ-021 In OUTPUT, out_data SHALL present final-layer neurons 0..N-1 in order; out_valid and out_data SHALL hold stable until out_ready is sampled high.
REQ-022 done SHALL pulse in the cycle after the last output beat is accepted, coincident with the return to IDLE.
REQ-023 start SHALL be ignored while busy; load_valid outside LOAD and out_ready outside OUTPUT SHALL have no effect.

Reset
REQ-024 While reset is high, the FSM SHALL be in IDLE and busy, done, load_ready, out_valid, weight_addr and the accumulator SHALL be 0.
REQ-025 Reset asserted mid-run SHALL abort the run; buffer contents are undefined afterwards, and the next start begins a complete new run.

Configuration
REQ-026 With macro NEURAL_RELU_EN defined, every writeback result SHALL be max(result, 0) after saturation; without it, writeback results SHALL pass through signed and unclamped.

Structure
REQ-027 Package neural_pkg SHALL hold the FSM state enum, the default parameter constants, and the saturate function.
REQ-028 The multiply-accumulate-shift-saturate datapath SHALL be the sub-module nl_mac; the FSM, address counters and ping-pong buffers SHALL live in neural_layer_engine.

Verification
REQ-029 N=4, L=1, FRAC_BITS=0, identity weights, inputs 1,2,3,4 -> outputs 1,2,3,4; done pulses 24 cycles after the COMPUTE phase begins plus the output handshakes.
REQ-030 Set all weights to 127, inputs to 127, FRAC_BITS=0 -> every output is 127 (positive saturation); weights of -128 -> every output is -128 without NEURAL_RELU_EN and 0 with it.
REQ-031 L=2, FRAC_BITS=0, layer 0 weights = 2*identity, layer 1 = identity, inputs 1,2,3,4 -> outputs 2,4,6,8, proving the ping-pong swap.
REQ-032 Hold out_ready low for 5 cycles during OUTPUT -> out_valid and out_data stay stable, no beat is lost, and the output order is preserved.
REQ-033 Assert reset for 1 cycle mid-COMPUTE, then perform a fresh start and load of 1,2,3,4 with identity weights -> outputs are 1,2,3,4 with no residue from the aborted run.
REQ-034 Pulse start during COMPUTE -> there is no state change and no second run.

Source files
------------

// File: rtl/neural_pkg.sv
// rtl/neural_pkg.sv - shared state enum, default parameters and saturation helper for the layer engine
package neural_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_COMPUTE,
        S_OUTPUT
    } nl_state_e;

    localparam int NL_DATA_W    = 8;
    localparam int NL_ACC_W     = 20;
    localparam int NL_N         = 4;
    localparam int NL_L         = 2;
    localparam int NL_FRAC_BITS = 4;

    // Clamp a wide signed value into the range of a w-bit signed number.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

endpackage

// File: rtl/nl_mac.sv
// rtl/nl_mac.sv - multiply-accumulate, arithmetic shift and saturation datapath
// NEURAL_RELU_EN: when defined, negative writeback results are clamped to zero.
module nl_mac
    import neural_pkg::*;
#(
    parameter int DATA_W    = NL_DATA_W,
    parameter int ACC_W     = NL_ACC_W,
    parameter int FRAC_BITS = NL_FRAC_BITS
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear_i,
    input  logic                     en_i,
    input  logic signed [DATA_W-1:0] act_i,
    input  logic signed [DATA_W-1:0] weight_i,
    output logic signed [DATA_W-1:0] result_o
);

    logic signed [ACC_W-1:0]    acc_q;
    logic signed [ACC_W-1:0]    acc_d;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    shifted;
    logic signed [63:0]         sat;

    assign prod = act_i * weight_i;

    always_comb begin
        acc_d = acc_q;
        if (clear_i)
            acc_d = '0;
        else if (en_i)
            acc_d = acc_q + ACC_W'(prod);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            acc_q <= '0;
        else
            acc_q <= acc_d;
    end

    assign shifted = acc_q >>> FRAC_BITS;
    assign sat     = saturate(64'(shifted), DATA_W);

`ifdef NEURAL_RELU_EN
    assign result_o = (sat < 0) ? '0 : DATA_W'(sat);
`else
    assign result_o = DATA_W'(sat);
`endif

endmodule

// File: rtl/neural_layer_engine.sv
// rtl/neural_layer_engine.sv - multi-layer dense neuron engine: FSM, weight addressing, ping-pong activations
// NEURAL_RELU_EN (see nl_mac) selects ReLU clamping of every neuron result.
module neural_layer_engine
    import neural_pkg::*;
#(
    parameter int DATA_W    = NL_DATA_W,
    parameter int ACC_W     = NL_ACC_W,
    parameter int N         = NL_N,
    parameter int L         = NL_L,
    parameter int FRAC_BITS = NL_FRAC_BITS
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        load_valid,
    output logic                        load_ready,
    input  logic signed [DATA_W-1:0]    load_data,
    output logic [$clog2(L*N*N)-1:0]    weight_addr,
    input  logic signed [DATA_W-1:0]    weight_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [DATA_W-1:0]    out_data,
    output logic                        busy,
    output logic                        done
);

    localparam int AW = $clog2(L*N*N);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int LW = (L > 1) ? $clog2(L) : 1;
    localparam int PW = $clog2(N + 2);

    nl_state_e         state_q;
    logic [IW-1:0]     idx_q;
    logic [IW-1:0]     neuron_q;
    logic [LW-1:0]     layer_q;
    logic [PW-1:0]     phase_q;
    logic              sel_q;
    logic              done_q;

    logic signed [DATA_W-1:0] act_buf_q [2][N];
    logic signed [DATA_W-1:0] opnd_q;
    logic signed [DATA_W-1:0] mac_result;

    logic in_compute, issue, mac_clear, mac_en, wb;

    assign in_compute = (state_q == S_COMPUTE);
    assign issue      = in_compute && (phase_q < PW'(N));
    assign mac_clear  = in_compute && (phase_q == '0);
    assign mac_en     = in_compute && (phase_q != '0) && (phase_q <= PW'(N));
    assign wb         = in_compute && (phase_q == PW'(N + 1));

    assign busy        = (state_q != S_IDLE);
    assign load_ready  = (state_q == S_LOAD);
    assign out_valid   = (state_q == S_OUTPUT);
    assign done        = done_q;
    assign out_data    = out_valid ? act_buf_q[sel_q][idx_q] : '0;
    assign weight_addr = issue ? (AW'(layer_q) * AW'(N*N) + AW'(neuron_q) * AW'(N) + AW'(phase_q)) : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            neuron_q <= '0;
            layer_q  <= '0;
            phase_q  <= '0;
            sel_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_LOAD;
                        idx_q   <= '0;
                    end
                end
                S_LOAD: begin
                    if (load_valid) begin
                        idx_q <= idx_q + IW'(1);
                        if (idx_q == IW'(N - 1)) begin
                            state_q  <= S_COMPUTE;
                            idx_q    <= '0;
                            neuron_q <= '0;
                            layer_q  <= '0;
                            phase_q  <= '0;
                            sel_q    <= 1'b0;
                        end
                    end
                end
                S_COMPUTE: begin
                    if (phase_q == PW'(N + 1)) begin
                        phase_q <= '0;
                        if (neuron_q == IW'(N - 1)) begin
                            // Flip after every layer, including the last, so sel_q names the result buffer.
                            neuron_q <= '0;
                            sel_q    <= ~sel_q;
                            if (layer_q == LW'(L - 1)) begin
                                state_q <= S_OUTPUT;
                                idx_q   <= '0;
                            end else begin
                                layer_q <= layer_q + LW'(1);
                            end
                        end else begin
                            neuron_q <= neuron_q + IW'(1);
                        end
                    end else begin
                        phase_q <= phase_q + PW'(1);
                    end
                end
                S_OUTPUT: begin
                    if (out_ready) begin
                        idx_q <= idx_q + IW'(1);
                        if (idx_q == IW'(N - 1)) begin
                            state_q <= S_IDLE;
                            idx_q   <= '0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Operand is registered at issue so it lines up with the 1-cycle weight ROM read.
    always_ff @(posedge clk) begin
        if (load_ready && load_valid)
            act_buf_q[0][idx_q] <= load_data;
        if (wb)
            act_buf_q[~sel_q][neuron_q] <= mac_result;
        if (issue)
            opnd_q <= act_buf_q[sel_q][IW'(phase_q)];
    end

    nl_mac #(
        .DATA_W    (DATA_W),
        .ACC_W     (ACC_W),
        .FRAC_BITS (FRAC_BITS)
    ) u_mac (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (mac_clear),
        .en_i     (mac_en),
        .act_i    (opnd_q),
        .weight_i (weight_data),
        .result_o (mac_result)
    );

endmodule

// File: tb/tb_neural_layer_engine.sv
// tb/tb_neural_layer_engine.sv - directed self-checking bench for neural_layer_engine (N=4, L=2, FRAC_BITS=0)
module tb_neural_layer_engine;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              load_valid;
    logic              load_ready;
    logic signed [7:0] load_data;
    logic [4:0]        weight_addr;
    logic signed [7:0] weight_data;
    logic              out_valid;
    logic              out_ready;
    logic signed [7:0] out_data;
    logic              busy;
    logic              done;

    logic signed [7:0] rom [32];
    int in_v  [4];
    int exp_v [4];
    int n_checks = 0;
    int n_fail   = 0;

    neural_layer_engine #(
        .DATA_W    (8),
        .ACC_W     (20),
        .N         (4),
        .L         (2),
        .FRAC_BITS (0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_data   (load_data),
        .weight_addr (weight_addr),
        .weight_data (weight_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) weight_data <= rom[weight_addr];

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // mode 0: v*identity, 1: rotate (out[j] = in[j+1]), 2: every weight = v
    task automatic set_layer(input int l, input int mode, input int v);
        for (int j = 0; j < 4; j++)
            for (int k = 0; k < 4; k++)
                case (mode)
                    0:       rom[l*16 + j*4 + k] = 8'((j == k) ? v : 0);
                    1:       rom[l*16 + j*4 + k] = 8'((k == (j + 1) % 4) ? 1 : 0);
                    default: rom[l*16 + j*4 + k] = 8'(v);
                endcase
    endtask

    task automatic set_vec(input int a0, input int a1, input int a2, input int a3,
                           input int e0, input int e1, input int e2, input int e3);
        in_v[0] = a0; in_v[1] = a1; in_v[2] = a2; in_v[3] = a3;
        exp_v[0] = e0; exp_v[1] = e1; exp_v[2] = e2; exp_v[3] = e3;
    endtask

    task automatic start_and_load();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_in_load", busy, 1);
        for (int i = 0; i < 4; i++) begin
            check("load_ready", load_ready, 1);
            load_valid = 1'b1;
            load_data  = 8'(in_v[i]);
            @(negedge clk);
        end
        load_valid = 1'b0;
        check("load_ready_off", load_ready, 0);
    endtask

    task automatic run_vec(input bit stall, input bit poke);
        int cyc;
        start_and_load();
        cyc = 0;
        while (!out_valid && cyc < 500) begin
            start = poke && (cyc == 10);
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        check("compute_cycles", cyc, 48);
        for (int i = 0; i < 4; i++) begin
            if (stall && i == 1) begin
                repeat (5) begin
                    @(negedge clk);
                    check("stall_valid", out_valid, 1);
                    check("stall_data", out_data, exp_v[1]);
                end
            end
            check("out_valid", out_valid, 1);
            check("out_data", out_data, exp_v[i]);
            check("done_low", done, 0);
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
        check("done_pulse", done, 1);
        check("busy_idle", busy, 0);
        @(negedge clk);
        check("done_cleared", done, 0);
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        out_ready  = 1'b0;
        for (int i = 0; i < 32; i++) rom[i] = '0;

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_load_ready", load_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_weight_addr", weight_addr, 0);
        check("rst_acc", dut.u_mac.acc_q, 0);
        reset = 1'b0;

        // load_valid and out_ready while idle do nothing
        load_valid = 1'b1;
        out_ready  = 1'b1;
        @(negedge clk);
        check("idle_ignores", busy, 0);
        load_valid = 1'b0;
        out_ready  = 1'b0;

        set_layer(0, 0, 1);
        set_layer(1, 0, 1);
        set_vec(1, 2, 3, 4, 1, 2, 3, 4);
        run_vec(1'b0, 1'b0);

        set_layer(0, 0, 2);
        set_vec(1, 2, 3, 4, 2, 4, 6, 8);
        run_vec(1'b1, 1'b0);

        set_layer(0, 1, 0);
        set_vec(1, 2, 3, 4, 2, 3, 4, 1);
        run_vec(1'b0, 1'b0);

        set_layer(0, 2, 127);
        set_layer(1, 2, 127);
        set_vec(127, 127, 127, 127, 127, 127, 127, 127);
        run_vec(1'b0, 1'b0);

        set_layer(0, 2, -128);
        set_layer(1, 0, 1);
`ifdef NEURAL_RELU_EN
        set_vec(127, 127, 127, 127, 0, 0, 0, 0);
`else
        set_vec(127, 127, 127, 127, -128, -128, -128, -128);
`endif
        run_vec(1'b0, 1'b0);

        set_layer(0, 0, 1);
        set_vec(1, 2, 3, 4, 1, 2, 3, 4);
        run_vec(1'b0, 1'b1);
        repeat (3) begin
            @(negedge clk);
            check("no_second_run", busy, 0);
        end

        // abort mid-compute with different data, then a clean run
        set_layer(0, 2, 5);
        set_vec(9, 9, 9, 9, 0, 0, 0, 0);
        start_and_load();
        repeat (20) @(negedge clk);
        check("mid_busy", busy, 1);
        reset = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_weight_addr", weight_addr, 0);
        check("abort_acc", dut.u_mac.acc_q, 0);
        check("abort_out_valid", out_valid, 0);
        @(negedge clk);
        reset = 1'b0;
        set_layer(0, 0, 1);
        set_vec(1, 2, 3, 4, 1, 2, 3, 4);
        run_vec(1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
